// File: rtl/ntt_poly_buffer.sv
// rtl/ntt_poly_buffer.sv - source/destination polynomial buffers serving an NTT core
module ntt_poly_buffer #(
    parameter int              LOGQ       = 64,
    parameter int              LOGN       = 4,
    parameter logic [LOGQ-1:0] Q          = 64'd18446744069414584321,
    parameter int              DELAY_BRAM = 1,
    localparam int             AW         = ((LOGN < 9) ? 9 : LOGN) + 1
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [LOGQ-1:0] in_data,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [LOGQ-1:0] out_data,
    output logic            out_last,

    output logic            busy,

    output logic [LOGQ-1:0] q,
    output logic            ntt_start,
    input  logic [AW-1:0]   ntt_read_address,
    output logic [LOGQ-1:0] ntt_data_in,
    input  logic [AW-1:0]   ntt_write_address,
    input  logic            ntt_wea,
    input  logic [LOGQ-1:0] ntt_data_out,
    input  logic            ntt_finish
);

    localparam int            N        = 1 << LOGN;
    localparam logic [LOGN:0] LAST_IDX = (LOGN + 1)'(N - 1);
    localparam logic [LOGN:0] N_WORDS  = (LOGN + 1)'(N);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Separate arrays so the core may write back in place without
    // disturbing source coefficients it has not read yet.
    logic [LOGQ-1:0] src_mem [N];
    logic [LOGQ-1:0] dst_mem [N];

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [LOGN:0]   ld_cnt;
    logic [LOGN:0]   fetch_cnt;
    logic            load_hs;
    logic            out_hs;
    logic            fetch_en;
    logic [LOGQ-1:0] rd_s1;

    // Only the low LOGN address bits select a coefficient.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ntt_read_address[AW-1:LOGN], ntt_write_address[AW-1:LOGN]};

    assign load_hs  = (state == ST_LOAD) && in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    // Refill the output register whenever it is empty or being consumed.
    assign fetch_en = (state == ST_DRAIN) && (fetch_cnt != N_WORDS) && (!out_valid || out_ready);

    // Next-state selection for LOAD -> RUN -> DRAIN -> LOAD.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: begin
                if (load_hs && (ld_cnt == LAST_IDX)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ntt_finish) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_hs && out_last) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    // State, load counter and registered status outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_LOAD;
            ld_cnt    <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            ntt_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == ST_LOAD);
            busy      <= (state_nxt != ST_LOAD);
            ntt_start <= (state_nxt == ST_RUN);
            if (load_hs) begin
                ld_cnt <= (ld_cnt == LAST_IDX) ? '0 : ld_cnt + 1'b1;
            end
        end
    end

    // Host load path into the source buffer.
    always_ff @(posedge clk) begin
        if (!rst && load_hs) begin
            src_mem[ld_cnt[LOGN-1:0]] <= in_data;
        end
    end

    // Core write-back into the destination buffer, accepted only while running.
    always_ff @(posedge clk) begin
        if (!rst && (state == ST_RUN) && ntt_wea) begin
            dst_mem[ntt_write_address[LOGN-1:0]] <= ntt_data_out;
        end
    end

    // First read stage: registered source-buffer read for the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_s1 <= '0;
        end else begin
            rd_s1 <= src_mem[ntt_read_address[LOGN-1:0]];
        end
    end

    generate
        if (DELAY_BRAM == 2) begin : g_rd_two
            logic [LOGQ-1:0] rd_s2;
            // Optional second read stage to mimic an output-registered BRAM.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_s2 <= '0;
                end else begin
                    rd_s2 <= rd_s1;
                end
            end
            assign ntt_data_in = rd_s2;
        end else begin : g_rd_one
            assign ntt_data_in = rd_s1;
        end
    endgenerate

    // Result output register: fetches dst in index order and holds under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            fetch_cnt <= '0;
        end else if (fetch_en) begin
            out_data  <= dst_mem[fetch_cnt[LOGN-1:0]];
            out_last  <= (fetch_cnt == LAST_IDX);
            out_valid <= 1'b1;
            fetch_cnt <= fetch_cnt + 1'b1;
        end else if (out_hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
                fetch_cnt <= '0;
            end
        end
    end

    // Modulus register toward the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= Q;
        end
    end

endmodule
